// File: rtl/pedal_pkg.sv
// Shared types and helpers for the pedal mode crossfade path.
package pedal_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    SETTLE    = 2'd2,
    RAMP_UP   = 2'd3
  } xfade_state_t;

  function automatic int gain_full(input int gw);
    return 1 << gw;
  endfunction

  // Channel c occupies bits [c*dw +: dw] of the flat sample buses.
  function automatic int ch_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// 2-FF synchroniser plus stability counter for raw switch inputs.
// Debounced value follows the synced value once it has held for STABLE_CYC cycles.
module sw_debounce #(
  parameter int             W          = 2,
  parameter int             STABLE_CYC = 1000000,
  parameter logic [W-1:0]   INIT       = '0
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] debounced
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYC - 1);

  logic [W-1:0]  sync_a;
  logic [W-1:0]  sync_b;
  logic [W-1:0]  last;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_a    <= INIT;
      sync_b    <= INIT;
      last      <= INIT;
      cnt       <= '0;
      debounced <= INIT;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b != last) begin
        last <= sync_b;
        cnt  <= '0;
      end else if (cnt != CNT_DONE) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Counter saturates; value has been stable long enough.
        debounced <= last;
      end
    end
  end

endmodule

// File: rtl/pedal_mode_xfade.sv
// Click-free mode switcher: debounced mode changes fade gain to zero, swap mode, settle, fade back.
// Output is one cycle after each in_valid strobe; no backpressure, the FSM only advances on strobes.
module pedal_mode_xfade
  import pedal_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DW             = 16,
  parameter int MODE_W         = 2,
  parameter int GW             = 8,
  parameter int RAMP_STEP      = 1,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int SETTLE_SAMPLES = 4,
  parameter int INIT_MODE      = 0
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic [MODE_W-1:0]    sw,
  input  logic                 in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic                 out_valid,
  output logic [NUM_CH*DW-1:0] out_data,
  output logic [MODE_W-1:0]    mode_active,
  output logic                 busy
);

  localparam int              FULL      = gain_full(GW);
  localparam logic [GW:0]     GAIN_FULL = FULL[GW:0];
  localparam logic [GW:0]     STEP      = RAMP_STEP[GW:0];
  localparam int              SCW       = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_SAMPLES - 1);
  localparam logic [MODE_W-1:0] MODE_INIT = MODE_W'(INIT_MODE);
  localparam int              PW        = DW + GW + 1;

  xfade_state_t        state;
  xfade_state_t        next_state;
  logic [GW:0]         gain;
  logic [GW:0]         gain_next;
  logic [MODE_W-1:0]   deb_mode;
  logic [MODE_W-1:0]   mode_next;
  logic [SCW-1:0]      settle_cnt;
  logic [SCW-1:0]      settle_next;
  logic [NUM_CH*DW-1:0] scaled;

  sw_debounce #(
    .W          (MODE_W),
    .STABLE_CYC (DEBOUNCE_CYC),
    .INIT       (MODE_INIT)
  ) u_sw_debounce (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .raw       (sw),
    .debounced (deb_mode)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state       <= IDLE;
      gain        <= GAIN_FULL;
      mode_active <= MODE_INIT;
      settle_cnt  <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state       <= next_state;
      gain        <= gain_next;
      mode_active <= mode_next;
      settle_cnt  <= settle_next;
      busy        <= (next_state != IDLE);
      out_valid   <= in_valid;
      if (in_valid) begin
        out_data <= scaled;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (deb_mode != mode_active) next_state = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (deb_mode == mode_active) next_state = RAMP_UP;
          else if (gain <= STEP)       next_state = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) next_state = RAMP_UP;
        end
        RAMP_UP: begin
          if (deb_mode != mode_active)       next_state = RAMP_DOWN;
          else if (gain >= GAIN_FULL - STEP) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Direction reversals keep the current gain for the turnaround frame.
  always_comb begin
    gain_next   = gain;
    mode_next   = mode_active;
    settle_next = settle_cnt;
    if (in_valid) begin
      case (state)
        IDLE: begin
          gain_next = GAIN_FULL;
        end
        RAMP_DOWN: begin
          if (deb_mode != mode_active) begin
            gain_next = (gain > STEP) ? gain - STEP : '0;
          end
          if (next_state == SETTLE) begin
            mode_next   = deb_mode;
            settle_next = '0;
          end
        end
        SETTLE: begin
          settle_next = settle_cnt + 1'b1;
        end
        RAMP_UP: begin
          if (deb_mode == mode_active) begin
            gain_next = (gain < GAIN_FULL - STEP) ? gain + STEP : GAIN_FULL;
          end
        end
        default: gain_next = GAIN_FULL;
      endcase
    end
  end

  // Frames are scaled by the gain held before this frame's update.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DW-1:0] sample;
    logic signed [PW-1:0] prod;
    assign sample = in_data[ch_lsb(c, DW) +: DW];
    assign prod   = PW'(sample) * PW'($signed({1'b0, gain}));
    assign scaled[ch_lsb(c, DW) +: DW] = DW'(prod >>> GW);
  end

endmodule

// File: doc/pedal_mode_xfade.md
Name: pedal_mode_xfade

Overview:
Click-free mode switcher for the distortion pedal datapath, in the CLOCK_50 domain between the codec sample buses and the DAC.
- Synchronises and debounces the mode switches, then drives mode_active to the per-channel distortion instances.
- On every mode change, ramps output gain to zero, swaps mode, holds for a settle interval, and ramps back up.
- Generalises the fixed stereo/2-bit-mode path to NUM_CH channels, DW-bit samples and MODE_W-bit modes.

Parameters:
NUM_CH, 2, number of audio channels
DW, 16, signed sample width
MODE_W, 2, mode select width
GW, 8, gain fractional bits; unity gain = 2^GW
RAMP_STEP, 1, gain change per sample during ramps
DEBOUNCE_CYC, 1000000, CLOCK_50 cycles switch must be stable (20 ms)
SETTLE_SAMPLES, 4, zero-gain samples after mode swap
INIT_MODE, 0, mode after reset

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_n  in  1  synchronous, active-low reset
sw  in  MODE_W  raw asynchronous mode switches
in_valid  in  1  one-cycle strobe, new frame on in_data
in_data  in  NUM_CH*DW  processed samples, channel 0 in LSBs, signed
out_valid  out  1  one-cycle strobe, out_data updated
out_data  out  NUM_CH*DW  gain-scaled samples
mode_active  out  MODE_W  mode driving the distortion DSP and LCD
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is synchronous on reset_n=0 at the CLOCK_50 edge:
  - sync FFs and debounced mode = INIT_MODE; debounce counter = 0.
  - mode_active = INIT_MODE; gain = 2^GW; state = IDLE.
  - out_valid = 0, out_data = 0, busy = 0.
  - Reset mid-ramp abandons the ramp with no residual state.
- Switch input: 2-FF synchroniser, then debounce. The counter restarts on any change of the synced value. The debounced value updates when the synced value has been stable for DEBOUNCE_CYC consecutive cycles.
- Gain register: GW+1 bits unsigned, range 0..2^GW.
- Datapath, per channel, latency 1 cycle from in_valid:
  - out = (in × gain) >>> GW, arithmetic shift (floor).
  - Product width is DW+GW+1. Result always fits DW.
  - At gain 2^GW the output is bit-exact passthrough.
- The gain used for a frame is the register value before that frame's update.
- out_valid is asserted exactly on the cycle after each in_valid. out_data holds between strobes.
- FSM (gain changes only on in_valid):
  - IDLE: gain = 2^GW. If debounced != mode_active, go to RAMP_DOWN.
  - RAMP_DOWN: gain <= max(gain - RAMP_STEP, 0). On the update that writes 0, go to SETTLE and latch mode_active <= current debounced value.
    - If debounced == mode_active during RAMP_DOWN, go to RAMP_UP from the current gain; mode_active is unchanged.
  - SETTLE: count SETTLE_SAMPLES in_valids at gain 0, then go to RAMP_UP. Debounce changes are ignored until RAMP_UP.
  - RAMP_UP: gain <= min(gain + RAMP_STEP, 2^GW). On reaching 2^GW, go to IDLE.
    - If debounced != mode_active during RAMP_UP, go to RAMP_DOWN from the current gain.
- Multiple debounce changes during RAMP_DOWN: only the value present at the SETTLE entry is latched.
- mode_active changes only on SETTLE entry, so the DSP swaps only while the output is silent.
- Without in_valid strobes the FSM stalls in its current state. The debounce counter keeps running.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package pedal_pkg:
  - xfade_state_t enum {IDLE, RAMP_DOWN, SETTLE, RAMP_UP}.
  - GAIN_FULL = 1 << GW computation helper.
  - Channel slice index function for the flat in/out buses.
- Sub-module sw_debounce (params W, STABLE_CYC): 2-FF sync, counter and debounced output register. It is reused for future pushbutton inputs.
- Per-channel multiply/shift lives in a generate loop in the top of this block.

Test Plan:
All scenarios use DEBOUNCE_CYC=16 and in_valid every 8 cycles.
- Reset, sw=0, in_data ch0=0x4000, ch1=0xC000 -> out_valid one cycle after each in_valid, out_data identical to in_data, mode_active=0, busy=0.
- sw 0->2 held -> busy=1 after debounce. Ramp-down frame k (0-based, input 0x4000) gives out=0x4000×(256-k)/256, e.g. k=128 gives 0x2000. After 256 frames mode_active=2, then 4 frames of 0x0000, then 256 frames of ramp-up, then IDLE with busy=0.
- sw toggles 0/1 every 5 cycles for 200 cycles then settles at 0 -> debounced never changes, busy stays 0, mode_active=0, output unity throughout.
- Ramp-down reaches gain 100, then sw returns to 0 and is debounced -> RAMP_UP from 100, mode_active stays 0, gain=256 after 156 more frames, IDLE.
- Arithmetic edges: in=0xFFFF (-1) at gain 128 gives 0xFFFF. in=0x8000 at gain 256 gives 0x8000. in=0x7FFF at gain 1 gives 0x007F.
- reset_n low for 1 cycle during RAMP_DOWN (gain 50) -> next cycle gain=256, state IDLE, mode_active=INIT_MODE, out_valid=0, out_data=0.
